// File: rtl/pin_pkg.sv
// Shared definitions for the PIN entry collector and the PIN/code comparator:
// keypad codes, collector state encoding and the BCD nibble width.
package pin_pkg;

    localparam int NIB_W = 4;

    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_BKSP  = 4'hB;
    localparam logic [3:0] KEY_ENTER = 4'hC;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ENTRY   = 2'd1,
        ST_PRESENT = 2'd2
    } pin_state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/pin_idle_timer.sv
// Inactivity counter: counts while enabled, restarts on i_clr, and flags
// o_tc during the cycle it sits at TIMEOUT_CYC-1.
module pin_idle_timer #(
    parameter int TIMEOUT_CYC = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int CW = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] r_cnt;

    assign o_tc = i_en && (r_cnt == TC_VAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (!i_en || i_clr || o_tc)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/pin_entry_collector.sv
// Assembles keypad digits into a packed BCD PIN and holds it until acknowledged.
// Build option: define BACKSPACE_EN to give 0xB a backspace meaning in ENTRY.
module pin_entry_collector
    import pin_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int TIMEOUT_CYC = 50000000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      key_valid,
    input  logic [3:0]                key_code,
    output logic                      key_ready,
    output logic [NIB_W*N_DIGITS-1:0] pin_out,
    output logic                      pin_valid,
    input  logic                      pin_ack,
    output logic [3:0]                digit_count,
    output logic                      key_err,
    output logic                      timeout
);

    localparam int         PW   = NIB_W * N_DIGITS;
    localparam logic [3:0] NCNT = 4'(N_DIGITS);

    pin_state_t      r_state;
    logic [PW-1:0]   r_pin;
    logic [3:0]      r_count;
    logic            r_key_ready;
    logic            r_pin_valid;
    logic            r_key_err;
    logic            r_timeout;
    logic            w_accept;
    logic            w_tc;
    logic            w_digit;

    assign w_accept = key_valid && r_key_ready;
    assign w_digit  = is_digit(key_code);

    pin_idle_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_idle_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_accept),
        .i_en  (r_state == ST_ENTRY),
        .o_tc  (w_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_pin       <= '0;
            r_count     <= '0;
            r_key_ready <= 1'b0;
            r_pin_valid <= 1'b0;
            r_key_err   <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_key_err   <= 1'b0;
            r_timeout   <= 1'b0;
            r_key_ready <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_digit) begin
                            r_pin             <= '0;
                            r_pin[PW-1 -: 4]  <= key_code;
                            r_count           <= 4'd1;
                            r_state           <= ST_ENTRY;
                        end else if (key_code != KEY_CLEAR) begin
                            r_key_err <= 1'b1;
                        end
                    end
                end
                ST_ENTRY: begin
                    // Expiry beats any event offered in the same cycle.
                    if (w_tc) begin
                        r_timeout <= 1'b1;
                        r_pin     <= '0;
                        r_count   <= '0;
                        r_state   <= ST_IDLE;
                    end else if (w_accept) begin
                        if (w_digit) begin
                            if (r_count < NCNT) begin
                                for (int i = 0; i < N_DIGITS; i++)
                                    if (4'(i) == r_count)
                                        r_pin[NIB_W*(N_DIGITS-1-i) +: NIB_W] <= key_code;
                                r_count <= r_count + 4'd1;
                            end else begin
                                r_key_err <= 1'b1;
                            end
                        end else if (key_code == KEY_CLEAR) begin
                            r_pin   <= '0;
                            r_count <= '0;
                            r_state <= ST_IDLE;
                        end else if (key_code == KEY_ENTER) begin
                            if (r_count == NCNT) begin
                                r_state     <= ST_PRESENT;
                                r_pin_valid <= 1'b1;
                                r_key_ready <= 1'b0;
                            end else begin
                                r_key_err <= 1'b1;
                            end
`ifdef BACKSPACE_EN
                        end else if (key_code == KEY_BKSP) begin
                            for (int i = 0; i < N_DIGITS; i++)
                                if (4'(i) == r_count - 4'd1)
                                    r_pin[NIB_W*(N_DIGITS-1-i) +: NIB_W] <= '0;
                            r_count <= r_count - 4'd1;
                            if (r_count == 4'd1)
                                r_state <= ST_IDLE;
`endif
                        end else begin
                            r_key_err <= 1'b1;
                        end
                    end
                end
                ST_PRESENT: begin
                    if (pin_ack) begin
                        r_pin_valid <= 1'b0;
                        r_pin       <= '0;
                        r_count     <= '0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_key_ready <= 1'b0;
                    end
                end
                default: begin
                    r_pin   <= '0;
                    r_count <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign key_ready   = r_key_ready;
    assign pin_out     = r_pin;
    assign pin_valid   = r_pin_valid;
    assign digit_count = r_count;
    assign key_err     = r_key_err;
    assign timeout     = r_timeout;

endmodule
